// File: rtl/div_pkg.sv
// Shared definitions for the sequential 64/32 divider.
//   WIDTH_DEFAULT : default divisor/quotient/remainder width
//   QUO_ALL_ONES  : saturated quotient returned for zero-divisor and overflow
//   div_state_e   : controller states
package div_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic [WIDTH_DEFAULT-1:0] QUO_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider.
//   master : drives CE, START, DIVIDEND, DIVISOR; observes BUSY, DONE, results
//   slave  : the divider side
interface seq_divider_if import div_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) ();

  logic                 CE;
  logic                 START;
  logic [2*WIDTH-1:0]   DIVIDEND;
  logic [WIDTH-1:0]     DIVISOR;
  logic                 BUSY;
  logic                 DONE;
  logic [WIDTH-1:0]     QUOTIENT;
  logic [WIDTH-1:0]     REMAINDER;
  logic                 DIV_BY_ZERO;
  logic                 OVERFLOW;

  modport master (
    output CE, START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW
  );

  modport slave (
    input  CE, START, DIVIDEND, DIVISOR,
    output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   r        : partial remainder, WIDTH+1 bits
//   q        : dividend low half being shifted out / quotient being shifted in
//   d        : divisor
//   r_nxt_c  : remainder after shift and conditional subtract
//   q_nxt_c  : q shifted left with the new quotient bit in bit 0
module div_step import div_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_nxt_c,
  output logic [WIDTH-1:0] q_nxt_c
);

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] t;
  logic             ge;

  // Shift {R,Q} left by one, then trial-subtract D with one guard bit for the sign.
  // A set top bit of R means the true shifted value exceeds D regardless of t.
  always_comb begin
    sh      = {r[WIDTH-1:0], q[WIDTH-1]};
    t       = {1'b0, sh} - {2'b00, d};
    ge      = r[WIDTH] | ~t[WIDTH+1];
    r_nxt_c = ge ? t[WIDTH:0] : sh;
    q_nxt_c = {q[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned 2W/W restoring divider with START/BUSY/DONE handshake.
//   CLK  : rising-edge clock
//   SCLR : synchronous active-high reset, overrides CE
//   bus  : seq_divider_if slave port
//          CE, START, DIVIDEND, DIVISOR in;
//          BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW out (all registered)
// A normal division spends WIDTH enabled cycles iterating with BUSY high, one
// write-back cycle, then presents DONE for one enabled cycle. Zero-divisor and
// overflow requests skip the iterations and present DONE right after START.
module seq_divider import div_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic          CLK,
  input logic          SCLR,
  seq_divider_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  // Replicate the package constant enough times to cover any WIDTH.
  localparam int unsigned SAT_REP = (WIDTH + WIDTH_DEFAULT - 1) / WIDTH_DEFAULT;
  localparam logic [WIDTH-1:0] QUO_SAT = WIDTH'({SAT_REP{QUO_ALL_ONES}});

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;
  logic             ov_q;

  logic [WIDTH-1:0] dvd_hi_c;
  logic [WIDTH-1:0] dvd_lo_c;
  logic             zero_c;
  logic             ovf_c;
  logic [WIDTH:0]   r_nxt_c;
  logic [WIDTH-1:0] q_nxt_c;

  // Request classification on the raw inputs; only used on the accepted START.
  assign dvd_hi_c = bus.DIVIDEND[2*WIDTH-1:WIDTH];
  assign dvd_lo_c = bus.DIVIDEND[WIDTH-1:0];
  assign zero_c   = (bus.DIVISOR == '0);
  assign ovf_c    = (dvd_hi_c >= bus.DIVISOR);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .q       (q_q),
    .d       (d_q),
    .r_nxt_c (r_nxt_c),
    .q_nxt_c (q_nxt_c)
  );

  // Controller, datapath registers and result registers.
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state  <= IDLE;
      cnt    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else if (bus.CE) begin
      unique case (state)
        IDLE: begin
          if (bus.START) begin
            if (zero_c) begin
              quo_q  <= QUO_SAT;
              rem_q  <= dvd_lo_c;
              dz_q   <= 1'b1;
              ov_q   <= 1'b0;
              done_q <= 1'b1;
              state  <= FIN;
            end else if (ovf_c) begin
              quo_q  <= QUO_SAT;
              rem_q  <= '0;
              dz_q   <= 1'b0;
              ov_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= FIN;
            end else begin
              r_q    <= {1'b0, dvd_hi_c};
              q_q    <= dvd_lo_c;
              d_q    <= bus.DIVISOR;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
        end

        RUN: begin
          if (cnt == CNT_W'(WIDTH)) begin
            // Write-back cycle: iterations are finished, publish the result.
            quo_q  <= q_q;
            rem_q  <= r_q[WIDTH-1:0];
            dz_q   <= 1'b0;
            ov_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end else begin
            r_q <= r_nxt_c;
            q_q <= q_nxt_c;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              busy_q <= 1'b0;
            end
          end
        end

        FIN: begin
          // DONE is visible for exactly this state; START here is dropped.
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.QUOTIENT    = quo_q;
  assign bus.REMAINDER   = rem_q;
  assign bus.DIV_BY_ZERO = dz_q;
  assign bus.OVERFLOW    = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH = 32).
// A cycle-level reference tracks, per enabled edge since an accepted START,
// what BUSY/DONE/results must be, using plain 64-bit arithmetic for the
// results; a negedge process compares every cycle. Directed tests add
// hand-computed literal expectations.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic CLK;
  logic SCLR;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .SCLR (SCLR),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference ----------------
  bit          m_active = 1'b0;
  int          m_n      = 0;
  logic [31:0] p_q, p_r;
  logic        e_busy, e_done, e_dz, e_ov;
  logic [31:0] e_q, e_r;

  always @(posedge CLK) begin
    logic [63:0] dvd;
    logic [31:0] dvs;
    if (SCLR) begin
      m_active = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_dz = 1'b0; e_ov = 1'b0;
      e_q = '0; e_r = '0;
    end else if (bus.CE) begin
      if (!m_active) begin
        if (bus.START) begin
          dvd = bus.DIVIDEND;
          dvs = bus.DIVISOR;
          m_active = 1'b1;
          if (dvs == 32'd0) begin
            e_q = 32'hFFFF_FFFF; e_r = dvd[31:0]; e_dz = 1'b1; e_ov = 1'b0;
            e_done = 1'b1; m_n = W + 1;
          end else if (dvd[63:32] >= dvs) begin
            e_q = 32'hFFFF_FFFF; e_r = 32'd0; e_dz = 1'b0; e_ov = 1'b1;
            e_done = 1'b1; m_n = W + 1;
          end else begin
            p_q = 32'(dvd / {32'd0, dvs});
            p_r = 32'(dvd % {32'd0, dvs});
            e_busy = 1'b1; m_n = 0;
          end
        end
      end else begin
        m_n++;
        if (m_n == W + 2) begin
          m_active = 1'b0; e_done = 1'b0;
        end else if (m_n == W + 1) begin
          e_done = 1'b1; e_q = p_q; e_r = p_r; e_dz = 1'b0; e_ov = 1'b0;
        end else if (m_n == W) begin
          e_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy",  64'(bus.BUSY),        64'(e_busy));
      chk("done",  64'(bus.DONE),        64'(e_done));
      chk("quot",  64'(bus.QUOTIENT),    64'(e_q));
      chk("rem",   64'(bus.REMAINDER),   64'(e_r));
      chk("dz",    64'(bus.DIV_BY_ZERO), 64'(e_dz));
      chk("ovf",   64'(bus.OVERFLOW),    64'(e_ov));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; holds START over pre+1 edges, then releases it.
  task automatic start_div(input logic [63:0] dvd, input logic [31:0] dvs, input int pre);
    bus.START = 1'b1; bus.DIVIDEND = dvd; bus.DIVISOR = dvs;
    repeat (pre + 1) @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  // Waits (bounded) for DONE; CE is dropped for gap_len cycles from gap_at.
  task automatic wait_done(input int gap_at, input int gap_len,
                           output int edges, output int en_edges, output int busy_cyc);
    edges = 0; en_edges = 0; busy_cyc = 0;
    for (int i = 0; i < 200 && !bus.DONE; i++) begin
      if (bus.BUSY) busy_cyc++;
      bus.CE = !(i >= gap_at && i < gap_at + gap_len);
      @(posedge CLK);
      edges++;
      if (bus.CE) en_edges++;
      @(negedge CLK);
    end
    bus.CE = 1'b1;
    chk("done_seen", 64'(bus.DONE), 64'd1);
  endtask

  task automatic leave_done();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int edges, en_edges, busy_cyc, dn;
    logic [31:0] a, b, c;
    logic [63:0] dvd;

    SCLR = 1'b1;
    bus.CE = 1'b1; bus.START = 1'b0; bus.DIVIDEND = '0; bus.DIVISOR = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;
    SCLR = 1'b0;
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_done", 64'(bus.DONE), 64'd0);
    chk("rst_quot", 64'(bus.QUOTIENT), 64'd0);
    chk("rst_rem",  64'(bus.REMAINDER), 64'd0);
    @(negedge CLK);

    // 100 / 7
    start_div(64'd100, 32'd7, 0);
    wait_done(1000, 0, edges, en_edges, busy_cyc);
    chk("t1_lat",  64'(edges), 64'd33);
    chk("t1_busy", 64'(busy_cyc), 64'd32);
    chk("t1_quot", 64'(bus.QUOTIENT), 64'd14);
    chk("t1_rem",  64'(bus.REMAINDER), 64'd2);
    chk("t1_flag", 64'({bus.DIV_BY_ZERO, bus.OVERFLOW}), 64'd0);
    leave_done();

    // multiplier round trip
    start_div(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 0);
    wait_done(1000, 0, edges, en_edges, busy_cyc);
    chk("t2_quot", 64'(bus.QUOTIENT), 64'hFFFF_FFFF);
    chk("t2_rem",  64'(bus.REMAINDER), 64'd0);
    leave_done();

    // divide by zero (also overflowing: zero divisor wins)
    start_div(64'h0000_0001_0000_0005, 32'd0, 0);
    wait_done(1000, 0, edges, en_edges, busy_cyc);
    chk("t3_lat",  64'(edges), 64'd0);
    chk("t3_busy", 64'(busy_cyc), 64'd0);
    chk("t3_quot", 64'(bus.QUOTIENT), 64'hFFFF_FFFF);
    chk("t3_rem",  64'(bus.REMAINDER), 64'd5);
    chk("t3_dz",   64'(bus.DIV_BY_ZERO), 64'd1);
    chk("t3_ov",   64'(bus.OVERFLOW), 64'd0);
    leave_done();

    // overflow
    start_div(64'h0000_0001_0000_0000, 32'd1, 0);
    wait_done(1000, 0, edges, en_edges, busy_cyc);
    chk("t4_lat",  64'(edges), 64'd0);
    chk("t4_quot", 64'(bus.QUOTIENT), 64'hFFFF_FFFF);
    chk("t4_rem",  64'(bus.REMAINDER), 64'd0);
    chk("t4_ov",   64'(bus.OVERFLOW), 64'd1);
    chk("t4_dz",   64'(bus.DIV_BY_ZERO), 64'd0);
    leave_done();

    // 100 / 7 with CE low for 5 cycles mid-RUN, then CE low while DONE
    start_div(64'd100, 32'd7, 0);
    wait_done(10, 5, edges, en_edges, busy_cyc);
    chk("t5_lat",   64'(edges), 64'd38);
    chk("t5_en",    64'(en_edges), 64'd33);
    chk("t5_quot",  64'(bus.QUOTIENT), 64'd14);
    chk("t5_rem",   64'(bus.REMAINDER), 64'd2);
    bus.CE = 1'b0;
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    chk("t5_hold",  64'(bus.DONE), 64'd1);
    bus.CE = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("t5_drop",  64'(bus.DONE), 64'd0);

    // START while busy is ignored; then START held in the DONE cycle
    start_div(64'd100, 32'd7, 0);
    repeat (5) @(negedge CLK);
    start_div(64'd1000, 32'd3, 1);
    wait_done(1000, 0, edges, en_edges, busy_cyc);
    chk("t6_quot", 64'(bus.QUOTIENT), 64'd14);
    chk("t6_rem",  64'(bus.REMAINDER), 64'd2);
    start_div(64'd50, 32'd5, 1);
    wait_done(1000, 0, edges, en_edges, busy_cyc);
    chk("t7_lat",  64'(edges), 64'd33);
    chk("t7_quot", 64'(bus.QUOTIENT), 64'd10);
    chk("t7_rem",  64'(bus.REMAINDER), 64'd0);
    leave_done();

    // SCLR around iteration 10 aborts the division
    start_div(64'd100, 32'd7, 0);
    repeat (10) @(negedge CLK);
    SCLR = 1'b1;
    @(posedge CLK); @(negedge CLK);
    SCLR = 1'b0;
    chk("t8_busy", 64'(bus.BUSY), 64'd0);
    chk("t8_quot", 64'(bus.QUOTIENT), 64'd0);
    chk("t8_rem",  64'(bus.REMAINDER), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.DONE) dn++;
    end
    chk("t8_nodone", 64'(dn), 64'd0);

    // A*B(+C)/B sweep
    for (int k = 0; k < 12; k++) begin
      a = $urandom;
      b = $urandom | 32'd1;
      c = (k < 6) ? 32'd0 : ($urandom % b);
      dvd = {32'd0, a} * {32'd0, b} + {32'd0, c};
      start_div(dvd, b, 0);
      wait_done(1000, 0, edges, en_edges, busy_cyc);
      chk("rt_quot", 64'(bus.QUOTIENT), 64'(a));
      chk("rt_rem",  64'(bus.REMAINDER), 64'(c));
      leave_done();
    end

    repeat (3) @(negedge CLK);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned 64/32 divider. It is the inverse of the 32x32→64 multiplier: it accepts a 64-bit dividend and a 32-bit divisor and returns a 32-bit quotient and a 32-bit remainder. It uses a radix-2 restoring algorithm with a START/BUSY/DONE handshake. It sits beside the multiplier in the arithmetic datapath and shares its CLK, SCLR and CE conventions.

## Interface

Parameters:
- WIDTH, default 32: divisor, quotient and remainder width. The dividend is 2*WIDTH.

Ports:
- CLK, input, 1: the single clock; all logic is on the rising edge.
- SCLR, input, 1: reset, synchronous and active-high.
- CE, input, 1: clock enable. When low, all state, counter and output registers hold.
- START, input, 1: request a division. Sampled only in IDLE with CE=1.
- DIVIDEND, input, 2*WIDTH: numerator. Captured on the accepted START.
- DIVISOR, input, WIDTH: denominator. Captured on the accepted START.
- BUSY, output, 1: high while a division is in progress (RUN state).
- DONE, output, 1: one-cycle pulse; results are valid from this cycle.
- QUOTIENT, output, WIDTH: result quotient.
- REMAINDER, output, WIDTH: result remainder.
- DIV_BY_ZERO, output, 1: the last result had DIVISOR = 0.
- OVERFLOW, output, 1: the last result had a quotient that does not fit in WIDTH bits (DIVIDEND[63:32] ≥ DIVISOR, DIVISOR ≠ 0).

## Operation

- States:
  - IDLE: waits for START.
  - RUN: WIDTH iterations.
  - FIN: one cycle, asserts DONE.
- IDLE → RUN on START with a nonzero, non-overflowing divisor. On that edge:
  - load R ← DIVIDEND[63:32] into a WIDTH+1-bit remainder register;
  - load Q ← DIVIDEND[31:0];
  - load D ← DIVISOR;
  - clear the iteration counter.
- IDLE → FIN on START with DIVISOR = 0:
  - QUOTIENT = all ones, REMAINDER = DIVIDEND[31:0];
  - DIV_BY_ZERO = 1, OVERFLOW = 0.
- IDLE → FIN on START with an overflowing dividend:
  - QUOTIENT = all ones, REMAINDER = 0;
  - OVERFLOW = 1, DIV_BY_ZERO = 0.
  - DIV_BY_ZERO takes priority over OVERFLOW.
- RUN iteration:
  - shift {R,Q} left by 1;
  - compute T = R − D over WIDTH+1 bits;
  - if T ≥ 0, set R ← T and Q[0] ← 1;
  - otherwise keep the shifted R and set Q[0] ← 0.
  - After WIDTH iterations, go to FIN.
- FIN:
  - QUOTIENT ← Q, REMAINDER ← R[WIDTH-1:0];
  - both flags are cleared on a normal result;
  - DONE = 1 for one cycle, then return to IDLE.
- QUOTIENT, REMAINDER and the flags hold their values until the next FIN.
- START in RUN or FIN is ignored; no queuing.
- DIVIDEND and DIVISOR are ignored except on the accepted START edge.

## Timing

- Reset values (SCLR=1 on an edge):
  - state = IDLE, counter = 0;
  - BUSY = 0, DONE = 0;
  - QUOTIENT = 0, REMAINDER = 0;
  - DIV_BY_ZERO = 0, OVERFLOW = 0.
- SCLR has priority over CE and aborts any division in flight; no DONE is produced for it.
- Normal division: START is accepted on edge t.
  - BUSY is high from after edge t through edge t+WIDTH.
  - DONE is high in the cycle after edge t+WIDTH+1, i.e. 33 enabled cycles after START for WIDTH=32.
- Zero-divisor or overflow division: DONE is high in the cycle after the START edge (latency 1), and BUSY stays low.
- CE=0 stretches latency cycle for cycle. DONE remains asserted while CE=0 in FIN; it deasserts on the first enabled edge.
- Back-to-back: START may be asserted in the DONE cycle. It is not accepted there; the earliest accepted START is the cycle after DONE.

## Structure

- Package div_pkg holds:
  - the state enumeration (IDLE, RUN, FIN);
  - WIDTH_DEFAULT = 32;
  - the all-ones quotient constant.
- One combinational sub-module, div_step, implements one restoring iteration:
  - inputs: R, Q, D;
  - outputs: next R, next Q.
- The top level holds the FSM, the counter and the output registers.

## Test plan

- DIVIDEND = 100, DIVISOR = 7, START one cycle → BUSY for 32 cycles; DONE at cycle 33 with QUOTIENT = 14, REMAINDER = 2, both flags 0.
- Multiplier round-trip: DIVIDEND = 0xFFFFFFFE00000001, DIVISOR = 0xFFFFFFFF → QUOTIENT = 0xFFFFFFFF, REMAINDER = 0. Also a random sweep checking A*B/B = A against a reference model.
- DIVISOR = 0, DIVIDEND = 0x0000000100000005 → DONE next cycle; QUOTIENT = 0xFFFFFFFF, REMAINDER = 5, DIV_BY_ZERO = 1.
- DIVIDEND = 0x0000000100000000, DIVISOR = 1 → DONE next cycle; OVERFLOW = 1, QUOTIENT = 0xFFFFFFFF, REMAINDER = 0.
- 100/7 with CE low for 5 cycles mid-RUN → DONE at cycle 38 with the same results.
- START again while BUSY with different operands → that START is ignored and the first result is produced.
- SCLR at iteration 10 → next cycle IDLE and all outputs 0; no DONE.
